fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch controller sitting between the 8-entry, 8-bit instruction memory and the decode stage. Owns the program counter and drives the memory address. Reads the combinational memory output and folds unconditional jumps (opcode 2'b11) inside fetch. Delivers non-jump instructions with their PC to decode through a small buffer with a valid/ready handshake, and supports external redirects and end-of-program detection.

Parameters:
PC_W, 8, program counter and address width
INSTR_W, 8, instruction width; opcode is [INSTR_W-1:INSTR_W-2], jump immediate is [5:0]
PROG_LEN, 6, first PC treated as past end of program
DEPTH, 2, output buffer entries (power of 2, at least 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-low
start  input  1  one-cycle pulse; leaves IDLE
imem_addr  output  PC_W  address to instruction memory, equals pc register
imem_data  input  INSTR_W  instruction memory read data, combinational from imem_addr
redirect_valid  input  1  redirect request from a later stage
redirect_pc  input  PC_W  redirect target
out_valid  output  1  buffer head valid
out_ready  input  1  decode accepts the head this cycle
out_instr  output  INSTR_W  head instruction; 0 when out_valid=0
out_pc  output  PC_W  head PC; 0 when out_valid=0
busy  output  1  state is FETCH or DRAIN
done  output  1  state is DONE
instr_count  output  8  instructions delivered (pop count), saturates at 255

Behaviour:
- Reset (rst=0 at a clk edge) sets: state IDLE, pc 0, buffer count 0, out_valid 0, done 0, busy 0, instr_count 0. A reset mid-operation discards buffer contents and any pending fold.
- States are IDLE, FETCH, DRAIN and DONE.
  - IDLE: no fetch. start goes to FETCH with pc unchanged (0 after reset).
  - FETCH: if pc >= PROG_LEN, go to DRAIN with no memory use. Otherwise fetch one instruction when count < DEPTH, or when count == DEPTH and a pop happens in the same cycle. With no room, stall and hold pc.
  - DRAIN: no fetch. Go to DONE in the cycle the buffer becomes empty; if already empty on entry, go to DONE next cycle.
  - DONE: done=1, holds. start behaves as in IDLE.
- Fetch action, same cycle as the read, zero-cycle memory latency:
  - Opcode 2'b11 (jump): pc <= pc + 1 + imm[5:0], zero-extended, mod 2^PC_W. Nothing is enqueued and instr_count is unchanged.
  - Any other opcode: enqueue {pc, imem_data} and set pc <= pc + 1.
  - A jump target >= PROG_LEN leads to DRAIN on the next FETCH cycle.
- Pop: out_valid && out_ready. The head is removed and instr_count increments, saturating at 255. out_valid is 1 whenever count > 0. The buffer is a circular FIFO with wrap-around pointers, so push and pop in one cycle keep count unchanged.
- Latency: an instruction fetched in cycle N is visible at the head in cycle N+1 at the earliest.
- Redirect: redirect_valid has highest priority after reset, in any state.
  - Buffer is flushed (count 0, so out_valid=0 next cycle).
  - pc <= redirect_pc and state <= FETCH.
  - No fetch result from that cycle is enqueued, and a jump fetched that cycle is ignored.
  - A pop in the same cycle still completes and counts.
- start outside IDLE/DONE, or together with redirect_valid, is ignored.
- imem_addr is always the pc register, even when not fetching.

Test Plan:
1. Program {0x23,0x61,0x1A,0xC1,0x5B,0x3C}, PROG_LEN=6, out_ready=1, start pulse -> delivered (pc,instr) sequence (0,0x23),(1,0x61),(2,0x1A),(5,0x3C); PC 4 is never delivered; done=1, instr_count=4.
2. Same program with out_ready=0 for 5 cycles after start -> count saturates at 2, pc holds at 2, out_instr stays 0x23; after release the sequence matches scenario 1 with no duplicates or drops.
3. redirect_valid with redirect_pc=4 while two entries are buffered, out_ready=1 -> head popped that cycle counts; out_valid=0 next cycle; next delivered is (4,0x5B), then (5,0x3C); then DONE.
4. Jump at PC 0 with imm 6 (0xC6), PROG_LEN=6 -> pc becomes 7; DRAIN then DONE with instr_count=0 and out_valid never asserted.
5. Reset asserted in FETCH with 2 entries buffered -> next cycle out_valid=0, pc=0, state IDLE, instr_count=0; start restarts from PC 0.
6. Redirect issued in DONE with redirect_pc=2 -> done falls next cycle; (2,0x1A) then (5,0x3C) are delivered; instr_count continues from its prior value.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, folds unconditional jumps inside fetch and
// hands non-jump instructions with their PC to decode through a small circular FIFO.
module fetch_sequencer #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 8,
    parameter int unsigned PROG_LEN = 6,
    parameter int unsigned DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               busy,
    output logic               done,
    output logic [7:0]         instr_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         instr_count_q, instr_count_d;
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic buf_valid, pop, push, fetch_en, is_jump, past_end;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StIdle, StDone: if (start) state_d = StFetch;
                StFetch:        if (past_end) state_d = StDrain;
                StDrain:        if (count_d == '0) state_d = StDone;
                default:        state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy      = (state_q == StFetch) || (state_q == StDrain);
        done      = (state_q == StDone);
        out_valid = buf_valid;
        out_instr = buf_valid ? instr_mem[rd_ptr_q] : '0;
        out_pc    = buf_valid ? pc_mem[rd_ptr_q] : '0;
    end

    assign imem_addr   = pc_q;
    assign instr_count = instr_count_q;
    assign buf_valid   = (count_q != '0);

    // Datapath: fetch, jump folding, FIFO bookkeeping
    always_comb begin
        pop      = buf_valid && out_ready;
        past_end = (pc_q >= PC_W'(PROG_LEN));
        is_jump  = (imem_data[INSTR_W-1 -: 2] == 2'b11);
        // A pop frees the slot this cycle, so a full buffer can still accept a fetch.
        fetch_en = (state_q == StFetch) && !redirect_valid && !past_end &&
                   ((count_q < CNT_W'(DEPTH)) || pop);
        push     = fetch_en && !is_jump;

        pc_d          = pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        instr_count_d = instr_count_q;

        if (pop && (instr_count_q != 8'hFF)) instr_count_d = instr_count_q + 8'd1;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch_en) begin
                if (is_jump) pc_d = pc_q + PC_W'(1) + PC_W'(imem_data[5:0]);
                else         pc_d = pc_q + PC_W'(1);
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            instr_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            pc_mem[wr_ptr_q]    <= pc_q;
            instr_mem[wr_ptr_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a combinational program memory model.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, redirect_valid, out_ready;
    logic [7:0] imem_addr, imem_data, redirect_pc, out_instr, out_pc, instr_count;
    logic       out_valid, busy, done;
    logic [7:0] prog [8];

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int base;
    int vbase;
    logic [15:0] rec [$];

    fetch_sequencer #(
        .PC_W(8), .INSTR_W(8), .PROG_LEN(6), .DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .busy(busy), .done(done), .instr_count(instr_count)
    );

    assign imem_data = prog[imem_addr[2:0]];

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            valid_cnt++;
            if (out_ready) rec.push_back({out_pc, out_instr});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 60) begin
            step();
            n++;
        end
        check({tag, "_done_reached"}, done, 1);
    endtask

    task automatic check_seq(input string tag, input int b, input int n,
                             input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({tag, "_len"}, rec.size() - b, n);
        for (int i = 0; i < n; i++) begin
            if (b + i < rec.size()) check($sformatf("%s_item%0d", tag, i), rec[b + i], e[i]);
        end
    endtask

    initial begin
        prog[0] = 8'h23; prog[1] = 8'h61; prog[2] = 8'h1A; prog[3] = 8'hC1;
        prog[4] = 8'h5B; prog[5] = 8'h3C; prog[6] = 8'h00; prog[7] = 8'h00;

        // Reset state
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", instr_count, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_pc", out_pc, 0);

        // 1: straight run with jump folding at PC 3
        base = rec.size();
        pulse_start();
        check("s1_busy", busy, 1);
        wait_done("s1");
        check_seq("s1_seq", base, 4, 16'h0023, 16'h0161, 16'h021A, 16'h053C);
        check("s1_count", instr_count, 4);
        repeat (3) step();
        check("s1_done_holds", done, 1);
        check("s1_out_valid", out_valid, 0);

        // 2: backpressure fills the buffer, pc stalls
        do_reset();
        out_ready = 1'b0;
        base = rec.size();
        pulse_start();
        repeat (5) step();
        check("s2_valid", out_valid, 1);
        check("s2_pc_hold", imem_addr, 2);
        check("s2_head_instr", out_instr, 8'h23);
        check("s2_head_pc", out_pc, 0);
        check("s2_count0", instr_count, 0);
        out_ready = 1'b1;
        wait_done("s2");
        check_seq("s2_seq", base, 4, 16'h0023, 16'h0161, 16'h021A, 16'h053C);
        check("s2_count", instr_count, 4);

        // 3: redirect with two entries buffered and a same-cycle pop
        do_reset();
        out_ready = 1'b0;
        base = rec.size();
        pulse_start();
        step();
        step();
        check("s3_pre_valid", out_valid, 1);
        check("s3_pre_addr", imem_addr, 2);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd4;
        step();
        redirect_valid = 1'b0;
        check("s3_flush", out_valid, 0);
        check("s3_addr", imem_addr, 4);
        check("s3_pop_counted", instr_count, 1);
        wait_done("s3");
        check_seq("s3_seq", base, 3, 16'h0023, 16'h045B, 16'h053C, 16'h0000);
        check("s3_count", instr_count, 3);

        // 4: jump past end of program at PC 0
        do_reset();
        prog[0] = 8'hC6;
        vbase = valid_cnt;
        pulse_start();
        wait_done("s4");
        check("s4_count", instr_count, 0);
        check("s4_never_valid", valid_cnt - vbase, 0);
        check("s4_addr", imem_addr, 7);
        prog[0] = 8'h23;

        // 5: reset mid-fetch with two entries buffered
        do_reset();
        pulse_start();
        repeat (3) step();
        out_ready = 1'b0;
        repeat (2) step();
        check("s5_pre_count", instr_count, 2);
        check("s5_pre_valid", out_valid, 1);
        check("s5_pre_head_pc", out_pc, 2);
        check("s5_pre_addr", imem_addr, 6);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("s5_valid", out_valid, 0);
        check("s5_addr", imem_addr, 0);
        check("s5_busy", busy, 0);
        check("s5_done", done, 0);
        check("s5_count", instr_count, 0);
        step();
        check("s5_idle_holds", busy, 0);
        out_ready = 1'b1;
        base = rec.size();
        pulse_start();
        wait_done("s5");
        check_seq("s5_seq", base, 4, 16'h0023, 16'h0161, 16'h021A, 16'h053C);
        check("s5_count_end", instr_count, 4);

        // 6: redirect from DONE; a simultaneous start is ignored
        base = rec.size();
        redirect_valid = 1'b1; redirect_pc = 8'd2; start = 1'b1;
        step();
        redirect_valid = 1'b0; start = 1'b0;
        check("s6_done_fall", done, 0);
        check("s6_busy", busy, 1);
        check("s6_addr", imem_addr, 2);
        wait_done("s6");
        check_seq("s6_seq", base, 2, 16'h021A, 16'h053C, 16'h0000, 16'h0000);
        check("s6_count", instr_count, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
